// File: rtl/matmul_sequencer_if.sv
// Control/status bundle between the matmul sequencer and its operand feeder, result drain and host.
// The master side issues jobs and flow control; the slave side is the sequencer.
interface matmul_sequencer_if #(
  parameter int N     = 4,
  parameter int CNT_W = 16
);
  localparam int STEP_W = $clog2(3*N-2);
  localparam int ROW_W  = $clog2(N);

  logic              start;
  logic              abort;
  logic              feed_stall;
  logic              drain_ready;
  logic              busy;
  logic              acc_clear;
  logic              feed_valid;
  logic [STEP_W-1:0] feed_step;
  logic              drain_valid;
  logic [ROW_W-1:0]  drain_row;
  logic              results_ready;
  logic [CNT_W-1:0]  done_count;

  modport master (
    output start, abort, feed_stall, drain_ready,
    input  busy, acc_clear, feed_valid, feed_step, drain_valid, drain_row,
           results_ready, done_count
  );

  modport slave (
    input  start, abort, feed_stall, drain_ready,
    output busy, acc_clear, feed_valid, feed_step, drain_valid, drain_row,
           results_ready, done_count
  );
endinterface

// File: rtl/matmul_sequencer.sv
// Job sequencer for an N x N systolic array: clear accumulators, feed 3N-2 skewed operand
// steps, drain N result rows, then pulse completion and count the finished job.
module matmul_sequencer #(
  parameter int N     = 4,
  parameter int CNT_W = 16
) (
  input  logic                 S_AXI_ACLK,
  input  logic                 S_AXI_ARESET,
  matmul_sequencer_if.slave    bus
);
  localparam int STEP_W = $clog2(3*N-2);
  localparam int ROW_W  = $clog2(N);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(3*N-3);
  localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(N-1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_COMPUTE,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              busy_q, busy_d;
  logic              acc_clear_q, acc_clear_d;
  logic              compute_q, compute_d;
  logic              drain_valid_q, drain_valid_d;
  logic              results_ready_q, results_ready_d;

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
    state_d = state_q;
    step_d  = step_q;
    row_d   = row_q;
    count_d = count_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.abort) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        state_d = S_COMPUTE;
      end
      S_COMPUTE: begin
        if (!bus.feed_stall) begin
          if (step_q == LAST_STEP) state_d = S_DRAIN;
          else                     step_d  = step_q + STEP_W'(1);
        end
      end
      S_DRAIN: begin
        if (bus.drain_ready) begin
          if (row_q == LAST_ROW) begin
            state_d = S_DONE;
            count_d = count_q + CNT_W'(1);
          end else begin
            row_d = row_q + ROW_W'(1);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort cancels the job before it can complete, so the count must not advance either.
    if (state_q != S_IDLE && bus.abort) begin
      state_d = S_IDLE;
      count_d = count_q;
    end

    // Counters read zero whenever their phase is not active.
    if (state_d != S_COMPUTE) step_d = '0;
    if (state_d != S_DRAIN)   row_d  = '0;

    busy_d          = (state_d != S_IDLE);
    acc_clear_d     = (state_d == S_CLEAR);
    compute_d       = (state_d == S_COMPUTE);
    drain_valid_d   = (state_d == S_DRAIN);
    results_ready_d = (state_d == S_DONE);
  end

  always_ff @(posedge S_AXI_ACLK) begin
    // NOTE: state uses non-blocking assignments so every flop samples the pre-edge values.
    if (S_AXI_ARESET) begin
      state_q         <= S_IDLE;
      step_q          <= '0;
      row_q           <= '0;
      count_q         <= '0;
      busy_q          <= 1'b0;
      acc_clear_q     <= 1'b0;
      compute_q       <= 1'b0;
      drain_valid_q   <= 1'b0;
      results_ready_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      step_q          <= step_d;
      row_q           <= row_d;
      count_q         <= count_d;
      busy_q          <= busy_d;
      acc_clear_q     <= acc_clear_d;
      compute_q       <= compute_d;
      drain_valid_q   <= drain_valid_d;
      results_ready_q <= results_ready_d;
    end
  end

  // The feed enable drops in the same cycle the operand source stalls.
  assign bus.feed_valid    = compute_q & ~bus.feed_stall;
  assign bus.busy          = busy_q;
  assign bus.acc_clear     = acc_clear_q;
  assign bus.feed_step     = step_q;
  assign bus.drain_valid   = drain_valid_q;
  assign bus.drain_row     = row_q;
  assign bus.results_ready = results_ready_q;
  assign bus.done_count    = count_q;
endmodule

// File: tb/tb_matmul_sequencer.sv
// Scoreboard bench for matmul_sequencer (N=4, CNT_W=4): stimulus pushes expected
// clear/feed/drain/done events with their cycle numbers; a negedge monitor pops and compares.
module tb_matmul_sequencer;
  localparam int N     = 4;
  localparam int CNT_W = 4;
  localparam int STEPS = 3*N-2;

  typedef struct {
    int cyc;
    int val;
  } ev_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;

  ev_t exp_clr[$];
  ev_t exp_feed[$];
  ev_t exp_drain[$];
  ev_t exp_done[$];

  matmul_sequencer_if #(.N(N), .CNT_W(CNT_W)) bus ();

  matmul_sequencer #(.N(N), .CNT_W(CNT_W)) dut (
    .S_AXI_ACLK   (clk),
    .S_AXI_ARESET (rst),
    .bus          (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s at cycle %0d: got an event, expected none", name, cyc);
  endtask

  // Monitor: compares every event the DUT presents against the head of its queue.
  always @(negedge clk) begin
    ev_t e;
    if (bus.acc_clear === 1'b1) begin
      if (exp_clr.size() == 0) unexpected("acc_clear");
      else begin
        e = exp_clr.pop_front();
        check("acc_clear_cycle", cyc, e.cyc);
      end
    end
    if (bus.feed_valid === 1'b1) begin
      if (exp_feed.size() == 0) unexpected("feed_valid");
      else begin
        e = exp_feed.pop_front();
        check("feed_cycle", cyc, e.cyc);
        check("feed_step", bus.feed_step, e.val);
      end
    end
    if (bus.drain_valid === 1'b1 && bus.drain_ready === 1'b1) begin
      if (exp_drain.size() == 0) unexpected("drain_xfer");
      else begin
        e = exp_drain.pop_front();
        check("drain_cycle", cyc, e.cyc);
        check("drain_row", bus.drain_row, e.val);
      end
    end
    if (bus.results_ready === 1'b1) begin
      if (exp_done.size() == 0) unexpected("results_ready");
      else begin
        e = exp_done.pop_front();
        check("done_cycle", cyc, e.cyc);
        check("done_count", bus.done_count, e.val);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) tick();
  endtask

  task automatic peek();
    @(negedge clk);
  endtask

  task automatic push(input int kind, input int c, input int v);
    ev_t e;
    e.cyc = c;
    e.val = v;
    case (kind)
      0: exp_clr.push_back(e);
      1: exp_feed.push_back(e);
      2: exp_drain.push_back(e);
      default: exp_done.push_back(e);
    endcase
  endtask

  // Unstalled job whose start is sampled at the end of cycle c.
  task automatic push_job(input int c, input int cnt);
    push(0, c + 1, 0);
    for (int k = 0; k < STEPS; k++) push(1, c + 2 + k, k);
    for (int r = 0; r < N; r++) push(2, c + 2 + STEPS + r, r);
    push(3, c + 2 + STEPS + N, cnt);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_acc_clear"}, bus.acc_clear, 0);
    check({tag, "_feed_valid"}, bus.feed_valid, 0);
    check({tag, "_feed_step"}, bus.feed_step, 0);
    check({tag, "_drain_valid"}, bus.drain_valid, 0);
    check({tag, "_drain_row"}, bus.drain_row, 0);
    check({tag, "_results_ready"}, bus.results_ready, 0);
    check({tag, "_done_count"}, bus.done_count, 0);
  endtask

  initial begin
    int c;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.feed_stall = 1'b0;
    bus.drain_ready = 1'b1;

    tick();
    tick();
    tick();
    peek();
    check_reset_outputs("reset");
    tick();
    rst = 1'b0;
    tick();

    // Plain job: clear at c+1, feed c+2..c+11, drain c+12..c+15, done c+16.
    c = cyc;
    bus.start = 1'b1;
    push_job(c, 1);
    tick();
    bus.start = 1'b0;
    wait_until(c + 17);
    peek();
    check("job1_busy_after", bus.busy, 0);
    check("job1_count_after", bus.done_count, 1);

    // Feed stall at step 5 for 3 cycles, drain backpressure at row 2 for 2 cycles.
    c = cyc;
    bus.start = 1'b1;
    push(0, c + 1, 0);
    for (int k = 0; k < 5; k++) push(1, c + 2 + k, k);
    for (int k = 5; k < STEPS; k++) push(1, c + 5 + k, k);
    push(2, c + 15, 0);
    push(2, c + 16, 1);
    push(2, c + 19, 2);
    push(2, c + 20, 3);
    push(3, c + 21, 2);
    tick();
    bus.start = 1'b0;
    while (cyc <= c + 22) begin
      bus.feed_stall  = (cyc >= c + 7 && cyc <= c + 9) || cyc == c + 15 || cyc == c + 16;
      bus.drain_ready = !((cyc >= c + 2 && cyc <= c + 6) || cyc == c + 17 || cyc == c + 18);
      if (cyc == c + 8) begin
        peek();
        check("stall_feed_step_hold", bus.feed_step, 5);
        check("stall_feed_valid_low", bus.feed_valid, 0);
      end
      if (cyc == c + 18) begin
        peek();
        check("bp_drain_row_hold", bus.drain_row, 2);
        check("bp_drain_valid_high", bus.drain_valid, 1);
      end
      tick();
    end
    bus.feed_stall = 1'b0;
    bus.drain_ready = 1'b1;

    // Second start during COMPUTE must be ignored.
    c = cyc;
    bus.start = 1'b1;
    push_job(c, 3);
    tick();
    bus.start = 1'b0;
    wait_until(c + 5);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_until(c + 25);
    peek();
    check("restart_count", bus.done_count, 3);
    check("restart_busy", bus.busy, 0);

    // Abort while drain_row=1.
    c = cyc;
    bus.start = 1'b1;
    push(0, c + 1, 0);
    for (int k = 0; k < STEPS; k++) push(1, c + 2 + k, k);
    push(2, c + 12, 0);
    tick();
    bus.start = 1'b0;
    wait_until(c + 13);
    bus.abort = 1'b1;
    bus.drain_ready = 1'b0;
    peek();
    check("abort_at_row", bus.drain_row, 1);
    tick();
    bus.abort = 1'b0;
    bus.drain_ready = 1'b1;
    peek();
    check("abort_busy", bus.busy, 0);
    check("abort_drain_valid", bus.drain_valid, 0);
    check("abort_count", bus.done_count, 3);
    tick();
    c = cyc;
    bus.start = 1'b1;
    push_job(c, 4);
    tick();
    bus.start = 1'b0;
    wait_until(c + 17);
    peek();
    check("post_abort_count", bus.done_count, 4);

    // Reset during COMPUTE at step 4.
    tick();
    c = cyc;
    bus.start = 1'b1;
    push(0, c + 1, 0);
    for (int k = 0; k < 5; k++) push(1, c + 2 + k, k);
    tick();
    bus.start = 1'b0;
    wait_until(c + 6);
    rst = 1'b1;
    tick();
    peek();
    check_reset_outputs("midreset");
    tick();
    rst = 1'b0;

    // start and abort together in IDLE: stays idle.
    bus.start = 1'b1;
    bus.abort = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      peek();
      check("start_abort_busy", bus.busy, 0);
    end
    bus.start = 1'b0;
    bus.abort = 1'b0;

    // 16 back-to-back jobs with start held high: 4-bit done_count wraps 15 -> 0.
    tick();
    c = cyc;
    bus.start = 1'b1;
    for (int k = 0; k < 16; k++) push_job(c + 17*k, (k + 1) % 16);
    wait_until(c + 17*15 + 1);
    bus.start = 1'b0;
    wait_until(c + 17*16 + 1);
    peek();
    check("wrap_count", bus.done_count, 0);
    check("wrap_busy", bus.busy, 0);

    tick();
    tick();
    tick();
    check("leftover_expected", exp_clr.size() + exp_feed.size() + exp_drain.size() + exp_done.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
